// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if: packed-BCD time word and blank control in, multiplexed display drive out.
// Master drives time/blank; slave (the scanner) drives anode/seg/dp.
interface seven_seg_scan_if;
  logic [13:0] time_In;
  logic        blank_En;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;

  modport master (output time_In, blank_En, input anode, seg, dp);
  modport slave  (input time_In, blank_En, output anode, seg, dp);
endinterface

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: 4-digit common-anode HH:MM scanner, snapshot per full scan, one-cycle registered outputs.
// Define COLON_BLINK_EN to build the colon blink counter on dp (digit 2); otherwise dp is held at 1.
module seven_seg_scan #(
  parameter int unsigned REFRESH_DIV = 100000
`ifdef COLON_BLINK_EN
  , parameter int unsigned BLINK_DIV = 50000000
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  seven_seg_scan_if.slave  bus
);
  localparam int unsigned   PW        = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [13:0]   r_snap;
  logic [3:0]    r_anode;
  logic [6:0]    r_seg;
  logic          w_tick;
  logic [6:0]    w_seg;

  assign w_tick = (r_presc == PRESC_MAX);

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Hour tens is only 2 bits wide: 0 is blanked, 3 is out of range.
  always_comb begin
    w_seg = 7'h7F;
    case (r_idx)
      2'd0: w_seg = bcd_to_seg(r_snap[3:0]);
      2'd1: w_seg = bcd_to_seg(r_snap[7:4]);
      2'd2: w_seg = bcd_to_seg(r_snap[11:8]);
      default: begin
        if (r_snap[13:12] == 2'd0)      w_seg = 7'h7F;
        else if (r_snap[13:12] == 2'd3) w_seg = 7'h3F;
        else                            w_seg = bcd_to_seg({2'b00, r_snap[13:12]});
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_snap  <= '0;
      r_anode <= 4'hF;
      r_seg   <= 7'h7F;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
        if (r_idx == 2'd3) r_snap <= bus.time_In;
      end
      if (bus.blank_En) begin
        r_anode <= 4'hF;
        r_seg   <= 7'h7F;
      end else begin
        r_anode <= ~(4'b0001 << r_idx);
        r_seg   <= w_seg;
      end
    end
  end

  assign bus.anode = r_anode;
  assign bus.seg   = r_seg;

`ifdef COLON_BLINK_EN
  localparam int unsigned   BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  logic          r_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_dp        <= 1'b1;
    end else begin
      if (r_blink_cnt == BLINK_MAX) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
      r_dp <= bus.blank_En | ~((r_idx == 2'd2) & r_phase);
    end
  end

  assign bus.dp = r_dp;
`else
  assign bus.dp = 1'b1;
`endif
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: scoreboarded bench; the reference derives each cycle's display from the cycle count since reset.
module tb_seven_seg_scan;
  localparam int RD   = 4;
  localparam int BD   = 8;
  localparam int SCAN = 4 * RD;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
  } obs_t;

  localparam obs_t RST_OBS = '{anode: 4'hF, seg: 7'h7F, dp: 1'b1};
  localparam logic [6:0] DIGIT_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seven_seg_scan_if bus();

  seven_seg_scan #(
    .REFRESH_DIV(RD)
`ifdef COLON_BLINK_EN
    , .BLINK_DIV(BD)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  obs_t        exp_q [$];
  int          tag_q [$];
  int          k;
  logic [13:0] snap_m;
  int          n_vec = 0;
  int          n_err = 0;

  // Display expected after edge k: digit = floor(k/RD) mod 4, showing the last word captured at a scan end.
  function automatic obs_t model(input int kk, input logic [13:0] snap, input logic bl);
    obs_t       o;
    int         idx;
    logic [3:0] v;
    idx     = (kk / RD) % 4;
    o.anode = 4'hF;
    o.seg   = 7'h7F;
    o.dp    = 1'b1;
    if (bl) return o;
    o.anode[idx] = 1'b0;
    case (idx)
      0:       v = snap[3:0];
      1:       v = snap[7:4];
      2:       v = snap[11:8];
      default: v = {2'b00, snap[13:12]};
    endcase
    if (idx == 3 && v == 4'd0)               o.seg = 7'h7F;
    else if (v > 4'd9 || (idx == 3 && v > 4'd2)) o.seg = 7'h3F;
    else                                     o.seg = DIGIT_TAB[v];
`ifdef COLON_BLINK_EN
    if (idx == 2 && ((kk / BD) % 2) == 1) o.dp = 1'b0;
`endif
    return o;
  endfunction

  task automatic check(input string name, input int tag, input obs_t got, input obs_t want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s k=%0d: got anode=%b seg=%h dp=%b, want anode=%b seg=%h dp=%b",
               name, tag, got.anode, got.seg, got.dp, want.anode, want.seg, want.dp);
    end
  endtask

  // Called at a negedge: drive inputs for the coming edge, predict its result, advance one cycle.
  task automatic step(input logic [13:0] ti, input logic bl);
    bus.time_In  = ti;
    bus.blank_En = bl;
    exp_q.push_back(model(k, snap_m, bl));
    tag_q.push_back(k);
    if (k % SCAN == SCAN - 1) snap_m = ti;
    k++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    obs_t got;
    rst_n = 1'b0;
    #1;
    got = {bus.anode, bus.seg, bus.dp};
    check("async_reset", k, got, RST_OBS);
    for (int i = 0; i < cycles; i++) begin
      exp_q.push_back(RST_OBS);
      tag_q.push_back(-1);
      @(negedge clk);
    end
    rst_n  = 1'b1;
    k      = 0;
    snap_m = 14'h0000;
  endtask

  function automatic logic [13:0] rand_bcd();
    return {2'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
  endfunction

  initial begin : monitor
    obs_t w;
    obs_t got;
    int   t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        w   = exp_q.pop_front();
        t   = tag_q.pop_front();
        got = {bus.anode, bus.seg, bus.dp};
        check((t < 0) ? "reset_hold" : "scan", t, got, w);
      end
    end
  end

  initial begin : driver
    logic [13:0] ti;
    bus.time_In  = 14'h0000;
    bus.blank_En = 1'b0;
    k      = 0;
    snap_m = 14'h0000;
    @(negedge clk);
    do_reset(3);

    for (int i = 0; i < SCAN; i++) step((i < 8) ? 14'h0000 : 14'h1234, 1'b0);
    for (int i = 0; i < SCAN; i++) step(14'h1234, 1'b0);
    // Word changes while digit 1 is lit; this scan must still show 12:34.
    for (int i = 0; i < SCAN; i++) step((i < 5) ? 14'h1234 : 14'h0959, 1'b0);
    for (int i = 0; i < SCAN; i++) step(14'h3AFC, 1'b0);
    for (int i = 0; i < SCAN; i++) step(14'h0000, 1'b0);

    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < SCAN; i++) begin
        ti = ($urandom_range(0, 3) == 0) ? 14'($urandom) : rand_bcd();
        step(ti, ($urandom_range(0, 7) == 0));
      end
    end

    for (int i = 0; i < 10; i++) step(14'h1858, 1'b1);
    for (int i = 0; i < 2 * SCAN; i++) step(14'h1858, 1'b0);

    while (k % SCAN != 2 * RD + 1) step(14'h2307, 1'b0);
    do_reset(2);
    for (int i = 0; i < 3 * SCAN; i++) step(14'h2147, 1'b0);

    @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
